// File: rtl/mcu_bus_master_pkg.sv
// Shared constants for the MCU bus master: FSM encodings, address spaces
// and the RAM page mask.
package mcu_bus_master_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic SPACE_RAM = 1'b1;
    localparam logic SPACE_ROM = 1'b0;

    localparam logic [15:0] RAM_ADDR_MASK = 16'h00FF;

    function automatic logic [7:0] sel_byte(input logic [15:0] word, input logic idx);
        return idx ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/mcu_bus_addr_inc.sv
// Next byte address for multi-byte accesses; RAM/SFR space wraps within its
// 256-byte page, ROM space wraps across the full address range.
module mcu_bus_addr_inc
    import mcu_bus_master_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              space,
    output logic [ADDR_W-1:0] addr_next
);

    always_comb begin
        addr_next = addr + ADDR_W'(1);
        if (space == SPACE_RAM) begin
            addr_next = {{(ADDR_W-8){1'b0}}, addr[7:0] + 8'd1};
        end
    end

endmodule

// File: rtl/mcu_bus_master.sv
// CPU-side initiator for the MCU memory bus: turns one- or two-byte requests
// into registered byte bus cycles with programmable wait states.
//
// state  | meaning
// IDLE   | ready for a request
// SETUP  | address/data driven, strobes low
// ACCESS | strobe high for 1+WAIT_CYC cycles, read byte taken on the last one
// DONE   | one-cycle response pulse
module mcu_bus_master
    import mcu_bus_master_pkg::*;
#(
    parameter int unsigned WAIT_CYC = 0,
    parameter int unsigned ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_ram,
    input  logic              req_len2,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_wdata,
    output logic              resp_valid,
    output logic [15:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] addr_bus,
    output logic [7:0]        wdata_bus,
    input  logic [7:0]        rdata_bus,
    output logic              read_en,
    output logic              write_en,
    output logic              memory_select,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(RAM_ADDR_MASK);

    logic [1:0]        state_q, state_d;
    logic              write_q, write_d;
    logic              ram_q, ram_d;
    logic              len2_q, len2_d;
    logic              err_q, err_d;
    logic              idx_q, idx_d;
    logic [2:0]        wait_q, wait_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [7:0]        byte0_q, byte0_d;
    logic [15:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [ADDR_W-1:0] addr_bus_q, addr_bus_d;
    logic [7:0]        wdata_bus_q, wdata_bus_d;
    logic              read_en_q, read_en_d;
    logic              write_en_q, write_en_d;
    logic              mem_sel_q, mem_sel_d;
    logic              req_ready_q, req_ready_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] addr_next;
    logic              accept;

    mcu_bus_addr_inc #(.ADDR_W(ADDR_W)) u_addr_inc (
        .addr      (addr_bus_q),
        .space     (ram_q),
        .addr_next (addr_next)
    );

    assign accept = req_valid && req_ready_q;

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        ram_d        = ram_q;
        len2_d       = len2_q;
        err_d        = err_q;
        idx_d        = idx_q;
        wait_d       = wait_q;
        wdata_d      = wdata_q;
        byte0_d      = byte0_q;
        resp_rdata_d = resp_rdata_q;
        addr_bus_d   = addr_bus_q;
        wdata_bus_d  = wdata_bus_q;
        mem_sel_d    = mem_sel_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    write_d = req_write;
                    ram_d   = req_ram;
                    len2_d  = req_len2;
                    wdata_d = req_wdata;
                    idx_d   = 1'b0;
                    err_d   = req_write && (req_ram == SPACE_ROM);
                    // A ROM write never reaches the bus, so the bus outputs keep their values.
                    if (err_d) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d     = ST_SETUP;
                        addr_bus_d  = (req_ram == SPACE_RAM) ? (req_addr & ADDR_MASK) : req_addr;
                        mem_sel_d   = req_ram;
                        wdata_bus_d = sel_byte(req_wdata, 1'b0);
                    end
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
                wait_d  = 3'(WAIT_CYC);
            end
            ST_ACCESS: begin
                if (wait_q != 3'd0) begin
                    wait_d = wait_q - 3'd1;
                end else begin
                    if (!write_q) begin
                        if (idx_q) begin
                            resp_rdata_d = {rdata_bus, byte0_q};
                        end else begin
                            byte0_d = rdata_bus;
                            if (!len2_q) begin
                                resp_rdata_d = {8'h00, rdata_bus};
                            end
                        end
                    end
                    if (len2_q && !idx_q) begin
                        idx_d       = 1'b1;
                        addr_bus_d  = addr_next;
                        wdata_bus_d = sel_byte(wdata_q, 1'b1);
                        state_d     = ST_SETUP;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Every output is a flop computed from the next state.
        read_en_d    = (state_d == ST_ACCESS) && !write_d;
        write_en_d   = (state_d == ST_ACCESS) && write_d;
        resp_valid_d = (state_d == ST_DONE);
        resp_err_d   = (state_d == ST_DONE) && err_d;
        req_ready_d  = (state_d == ST_IDLE);
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            write_q      <= 1'b0;
            ram_q        <= 1'b0;
            len2_q       <= 1'b0;
            err_q        <= 1'b0;
            idx_q        <= 1'b0;
            wait_q       <= 3'd0;
            wdata_q      <= 16'h0000;
            byte0_q      <= 8'h00;
            resp_rdata_q <= 16'h0000;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            addr_bus_q   <= '0;
            wdata_bus_q  <= 8'h00;
            read_en_q    <= 1'b0;
            write_en_q   <= 1'b0;
            mem_sel_q    <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            ram_q        <= ram_d;
            len2_q       <= len2_d;
            err_q        <= err_d;
            idx_q        <= idx_d;
            wait_q       <= wait_d;
            wdata_q      <= wdata_d;
            byte0_q      <= byte0_d;
            resp_rdata_q <= resp_rdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            addr_bus_q   <= addr_bus_d;
            wdata_bus_q  <= wdata_bus_d;
            read_en_q    <= read_en_d;
            write_en_q   <= write_en_d;
            mem_sel_q    <= mem_sel_d;
            req_ready_q  <= req_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_err      = resp_err_q;
    assign addr_bus      = addr_bus_q;
    assign wdata_bus     = wdata_bus_q;
    assign read_en       = read_en_q;
    assign write_en      = write_en_q;
    assign memory_select = mem_sel_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_mcu_bus_master.sv
// Bench for mcu_bus_master: two instances (WAIT_CYC 0 and 3) on a shared
// clock, a behavioural byte responder and a transaction-level expected model.
module tb_mcu_bus_master;

    localparam int ND = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid[ND], req_ready[ND], req_write[ND], req_ram[ND], req_len2[ND];
    logic [15:0] req_addr[ND], req_wdata[ND], resp_rdata[ND], addr_bus[ND];
    logic        resp_valid[ND], resp_err[ND], read_en[ND], write_en[ND];
    logic        memory_select[ND], busy[ND];
    logic [7:0]  wdata_bus[ND], rdata_bus[ND], junk[ND];

    for (genvar g = 0; g < ND; g++) begin : g_dut
        mcu_bus_master #(.WAIT_CYC(g * 3), .ADDR_W(16)) u_dut (
            .clk(clk), .reset(reset),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_write(req_write[g]),
            .req_ram(req_ram[g]), .req_len2(req_len2[g]), .req_addr(req_addr[g]),
            .req_wdata(req_wdata[g]), .resp_valid(resp_valid[g]), .resp_rdata(resp_rdata[g]),
            .resp_err(resp_err[g]), .addr_bus(addr_bus[g]), .wdata_bus(wdata_bus[g]),
            .rdata_bus(rdata_bus[g]), .read_en(read_en[g]), .write_en(write_en[g]),
            .memory_select(memory_select[g]), .busy(busy[g])
        );
    end

    function automatic logic [7:0] init_byte(input int a);
        if (a == 'h30) return 8'h5A;
        if (a == 'h50) return 8'hA5;
        return 8'(a * 3) ^ 8'hC3;
    endfunction

    function automatic logic [7:0] rom_byte(input logic [15:0] a);
        if (a == 16'hFFFF) return 8'h12;
        if (a == 16'h0000) return 8'h34;
        return a[7:0] ^ a[15:8] ^ 8'h6C;
    endfunction

    // Responder memory: presents real data only in the last wait-state cycle.
    logic [7:0] ram[ND][256];
    bit         ram_wr[ND][256];
    int         run_cnt[ND];

    always @(posedge clk) begin
        for (int g = 0; g < ND; g++) begin
            run_cnt[g] <= read_en[g] ? run_cnt[g] + 1 : 0;
        end
    end

    always @(posedge clk) begin
        for (int g = 0; g < ND; g++) begin
            if (write_en[g] && memory_select[g]) begin
                ram[g][addr_bus[g][7:0]] = wdata_bus[g];
                ram_wr[g][addr_bus[g][7:0]] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int g = 0; g < ND; g++) begin
            rdata_bus[g] = junk[g];
            if (read_en[g] && run_cnt[g] == g * 3) begin
                if (memory_select[g])
                    rdata_bus[g] = ram_wr[g][addr_bus[g][7:0]] ? ram[g][addr_bus[g][7:0]]
                                                               : init_byte(int'(addr_bus[g][7:0]));
                else
                    rdata_bus[g] = rom_byte(addr_bus[g]);
            end
        end
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs(input int d);
        return {17'b0, req_ready[d], resp_valid[d], resp_err[d], resp_rdata[d], addr_bus[d],
                wdata_bus[d], read_en[d], write_en[d], memory_select[d], busy[d]};
    endfunction

    localparam logic [63:0] RST_OUTS = {17'b0, 1'b1, 46'b0};

    // Observed transaction
    int          t_lat, t_nruns, t_bad;
    bit          t_timeout;
    logic [15:0] t_rdata;
    logic        t_err;
    logic [15:0] t_addr[2];
    logic [7:0]  t_wd[2];
    int          t_len[2];
    logic        t_wr[2], t_msel[2];

    // Expected transaction
    logic [7:0]  ref_ram[ND][256];
    logic [15:0] last_rdata[ND];
    int          e_lat, e_nruns;
    logic [15:0] e_rdata;
    logic        e_err;
    logic [15:0] e_addr[2];
    logic [7:0]  e_wd[2];
    int          e_len[2];
    logic        e_wr[2], e_msel[2];

    task automatic model(input int d, input logic wr, input logic rs, input logic l2,
                         input logic [15:0] a, input logic [15:0] wd);
        int w, nb, av;
        logic [7:0] b[2];
        w = d * 3;
        av = int'(a);
        b[0] = 8'h00;
        b[1] = 8'h00;
        for (int k = 0; k < 2; k++) begin
            e_addr[k] = '0; e_wd[k] = '0; e_len[k] = 0; e_wr[k] = 0; e_msel[k] = 0;
        end
        if (wr && !rs) begin
            e_err = 1'b1; e_nruns = 0; e_lat = 2; e_rdata = last_rdata[d];
            return;
        end
        nb = l2 ? 2 : 1;
        e_err = 1'b0;
        e_nruns = nb;
        e_lat = 2 + nb * (2 + w);
        for (int k = 0; k < nb; k++) begin
            e_addr[k] = rs ? 16'((av % 256 + k) % 256) : 16'((av + k) % 65536);
            e_wd[k]   = 8'(wd >> (8 * k));
            e_len[k]  = 1 + w;
            e_wr[k]   = wr;
            e_msel[k] = rs;
            if (wr) ref_ram[d][e_addr[k] % 256] = e_wd[k];
            else    b[k] = rs ? ref_ram[d][e_addr[k] % 256] : rom_byte(e_addr[k]);
        end
        e_rdata = wr ? last_rdata[d] : {b[1], b[0]};
        last_rdata[d] = e_rdata;
    endtask

    // Issue one request (called at a negedge, returns at a negedge).
    task automatic run_req(input int d, input logic wr, input logic rs, input logic l2,
                           input logic [15:0] a, input logic [15:0] wd);
        int c;
        logic prev, strb;
        logic [15:0] prev_addr;
        t_nruns = 0; t_bad = 0; t_timeout = 0; t_lat = 0; t_rdata = '0; t_err = 0;
        for (int k = 0; k < 2; k++) begin
            t_addr[k] = '0; t_wd[k] = '0; t_len[k] = 0; t_wr[k] = 0; t_msel[k] = 0;
        end
        req_write[d] = wr; req_ram[d] = rs; req_len2[d] = l2;
        req_addr[d] = a; req_wdata[d] = wd; req_valid[d] = 1'b1;
        c = 0;
        while (!req_ready[d] && c < 40) begin
            @(negedge clk);
            c++;
        end
        if (!req_ready[d]) begin
            t_timeout = 1;
            req_valid[d] = 1'b0;
            return;
        end
        @(negedge clk);
        c = 2;  // the accept cycle counts as the first
        prev = 1'b0;
        prev_addr = addr_bus[d];
        while (!resp_valid[d] && c < 60) begin
            // Requests offered while busy must be ignored.
            req_valid[d] = 1'($urandom); req_write[d] = 1'($urandom); req_ram[d] = 1'($urandom);
            req_len2[d] = 1'($urandom); req_addr[d] = 16'($urandom); req_wdata[d] = 16'($urandom);
            if (req_ready[d] || !busy[d]) t_bad++;
            if (read_en[d] && write_en[d]) t_bad++;
            strb = read_en[d] | write_en[d];
            if (strb && !prev) begin
                if (addr_bus[d] !== prev_addr) t_bad++;
                if (t_nruns < 2) begin
                    t_addr[t_nruns] = addr_bus[d]; t_wd[t_nruns] = wdata_bus[d];
                    t_wr[t_nruns] = write_en[d]; t_msel[t_nruns] = memory_select[d];
                    t_len[t_nruns] = 1;
                end
                t_nruns++;
            end else if (strb && t_nruns <= 2) begin
                t_len[t_nruns-1]++;
                if (addr_bus[d] !== t_addr[t_nruns-1] || wdata_bus[d] !== t_wd[t_nruns-1] ||
                    memory_select[d] !== t_msel[t_nruns-1] || write_en[d] !== t_wr[t_nruns-1])
                    t_bad++;
            end
            prev = strb;
            prev_addr = addr_bus[d];
            @(negedge clk);
            c++;
        end
        req_valid[d] = 1'b0;
        if (!resp_valid[d]) begin
            t_timeout = 1;
            return;
        end
        t_lat = c;
        t_rdata = resp_rdata[d];
        t_err = resp_err[d];
        if (read_en[d] || write_en[d] || !busy[d] || req_ready[d]) t_bad++;
        @(negedge clk);
        if (resp_valid[d] || !req_ready[d] || busy[d] || resp_rdata[d] !== t_rdata) t_bad++;
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, " timeout"}, 64'(t_timeout), 64'(0));
        chk({tag, " latency"}, 64'(t_lat), 64'(e_lat));
        chk({tag, " rdata"}, 64'(t_rdata), 64'(e_rdata));
        chk({tag, " err"}, 64'(t_err), 64'(e_err));
        chk({tag, " strobe runs"}, 64'(t_nruns), 64'(e_nruns));
        chk({tag, " protocol"}, 64'(t_bad), 64'(0));
        for (int k = 0; k < 2; k++) begin
            if (k < e_nruns) begin
                chk($sformatf("%s b%0d addr", tag, k), 64'(t_addr[k]), 64'(e_addr[k]));
                chk($sformatf("%s b%0d wdata", tag, k), 64'(t_wd[k]), 64'(e_wd[k]));
                chk($sformatf("%s b%0d strobe len", tag, k), 64'(t_len[k]), 64'(e_len[k]));
                chk($sformatf("%s b%0d write", tag, k), 64'(t_wr[k]), 64'(e_wr[k]));
                chk($sformatf("%s b%0d msel", tag, k), 64'(t_msel[k]), 64'(e_msel[k]));
            end
        end
    endtask

    typedef struct {
        int          d;
        logic        wr, rs, l2;
        logic [15:0] a, wd;
        logic [7:0]  jk;
        logic [15:0] x_rdata;
        logic        x_err;
        int          x_lat, x_nruns;
        logic [15:0] x_a0, x_a1;
        logic [7:0]  x_w0, x_w1;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int c, pulses;
        vecs[0] = '{0, 0, 1, 0, 16'h0030, 16'h0000, 8'h00, 16'h005A, 0, 4, 1, 16'h0030, 16'h0000, 8'h00, 8'h00};
        vecs[1] = '{0, 0, 0, 1, 16'hFFFF, 16'h0000, 8'hC3, 16'h3412, 0, 6, 2, 16'hFFFF, 16'h0000, 8'h00, 8'h00};
        vecs[2] = '{0, 1, 1, 1, 16'h00FF, 16'hBEEF, 8'h00, 16'h3412, 0, 6, 2, 16'h00FF, 16'h0000, 8'hEF, 8'hBE};
        vecs[3] = '{0, 1, 0, 0, 16'h1000, 16'h5555, 8'h00, 16'h3412, 1, 2, 0, 16'h0000, 16'h0000, 8'h00, 8'h00};
        vecs[4] = '{1, 0, 1, 0, 16'h0050, 16'h0000, 8'h00, 16'h00A5, 0, 7, 1, 16'h0050, 16'h0000, 8'h00, 8'h00};
        vecs[5] = '{1, 1, 1, 0, 16'h12FF, 16'h7766, 8'h00, 16'h00A5, 0, 7, 1, 16'h00FF, 16'h0000, 8'h66, 8'h00};
        vecs[6] = '{1, 0, 1, 1, 16'hAAFF, 16'h0000, 8'h5C, 16'hC366, 0, 12, 2, 16'h00FF, 16'h0000, 8'h00, 8'h00};
        vecs[7] = '{0, 0, 0, 0, 16'h1000, 16'h0000, 8'h00, 16'h007C, 0, 4, 1, 16'h1000, 16'h0000, 8'h00, 8'h00};

        for (int d = 0; d < ND; d++) begin
            req_valid[d] = 0; req_write[d] = 0; req_ram[d] = 0; req_len2[d] = 0;
            req_addr[d] = '0; req_wdata[d] = '0; junk[d] = 8'h00; last_rdata[d] = '0;
            for (int i = 0; i < 256; i++) ref_ram[d][i] = init_byte(i);
        end

        reset = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < ND; d++) chk($sformatf("reset outs dut%0d", d), outs(d), RST_OUTS);
        reset = 1'b1;
        @(negedge clk);
        for (int d = 0; d < ND; d++) chk($sformatf("idle outs dut%0d", d), outs(d), RST_OUTS);

        for (int v = 0; v < 8; v++) begin
            junk[vecs[v].d] = vecs[v].jk;
            model(vecs[v].d, vecs[v].wr, vecs[v].rs, vecs[v].l2, vecs[v].a, vecs[v].wd);
            run_req(vecs[v].d, vecs[v].wr, vecs[v].rs, vecs[v].l2, vecs[v].a, vecs[v].wd);
            chk($sformatf("vec%0d timeout", v), 64'(t_timeout), 64'(0));
            chk($sformatf("vec%0d rdata", v), 64'(t_rdata), 64'(vecs[v].x_rdata));
            chk($sformatf("vec%0d err", v), 64'(t_err), 64'(vecs[v].x_err));
            chk($sformatf("vec%0d latency", v), 64'(t_lat), 64'(vecs[v].x_lat));
            chk($sformatf("vec%0d strobe runs", v), 64'(t_nruns), 64'(vecs[v].x_nruns));
            if (vecs[v].x_nruns >= 1) begin
                chk($sformatf("vec%0d addr0", v), 64'(t_addr[0]), 64'(vecs[v].x_a0));
                chk($sformatf("vec%0d wdata0", v), 64'(t_wd[0]), 64'(vecs[v].x_w0));
            end
            if (vecs[v].x_nruns == 2) begin
                chk($sformatf("vec%0d addr1", v), 64'(t_addr[1]), 64'(vecs[v].x_a1));
                chk($sformatf("vec%0d wdata1", v), 64'(t_wd[1]), 64'(vecs[v].x_w1));
            end
            cmp_model($sformatf("vec%0d", v));
        end

        // Reset during the first ACCESS of a double read.
        req_write[0] = 0; req_ram[0] = 1; req_len2[0] = 1; req_addr[0] = 16'h0040;
        req_wdata[0] = '0; req_valid[0] = 1;
        @(negedge clk);
        req_valid[0] = 0;
        c = 0;
        while (!read_en[0] && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("rst reached access", 64'(read_en[0]), 64'(1));
        reset = 1'b0;
        @(negedge clk);
        chk("rst mid-access outs", outs(0), RST_OUTS);
        reset = 1'b1;
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (resp_valid[0] || read_en[0]) pulses++;
        end
        chk("rst no resp pulse", 64'(pulses), 64'(0));
        chk("rst idle outs", outs(0), RST_OUTS);
        for (int d = 0; d < ND; d++) last_rdata[d] = '0;
        model(0, 0, 0, 1, 16'h2000, 16'h0000);
        run_req(0, 0, 0, 1, 16'h2000, 16'h0000);
        cmp_model("post-reset");

        for (int i = 0; i < 150; i++) begin
            int d;
            logic wr, rs, l2;
            logic [15:0] a, wd;
            d = int'($urandom_range(0, ND - 1));
            wr = 1'($urandom); rs = 1'($urandom); l2 = 1'($urandom);
            a = 16'($urandom); wd = 16'($urandom);
            if (i % 8 == 0) a = rs ? 16'h00FF : 16'hFFFF;
            junk[d] = 8'($urandom);
            model(d, wr, rs, l2, a, wd);
            run_req(d, wr, rs, l2, a, wd);
            cmp_model($sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
